// File: rtl/spi_cfg_sequencer.sv
`timescale 1ns/1ps
// spi_cfg_sequencer
// Walks a host-loaded table of (register address, data) pairs and issues one SPI
// write per entry, optionally followed by a read-back compare with bounded retry.
// Reports progress, completion and verify failures to the host.
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// S_IDLE   | waiting for start; table writable
// S_FETCH  | load table[ptr] onto spi_addr/spi_wdata, rearm retry budget
// S_WRITE  | spi_wr_req high until spi_done
// S_GAP_W  | forced idle after a write so SPI_EN can deassert
// S_READ   | spi_rd_req high until spi_done; read-back byte captured
// S_GAP_R  | forced idle after a read
// S_CHECK  | compare read-back with written data; retry, flag error or move on
// S_NEXT   | advance ptr; fetch the next entry or finish
// S_FINISH | issue the done pulse and drop busy on the way back to idle
module spi_cfg_sequencer #(
  parameter int DEPTH     = 16,
  parameter int MAX_RETRY = 2,
  parameter int GAP       = 2,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic          FSM_Clk,
  input  logic          Reset,
  input  logic          tbl_we,
  input  logic [AW-1:0] tbl_idx,
  input  logic [6:0]    tbl_addr,
  input  logic [7:0]    tbl_data,
  input  logic [AW:0]   n_pairs,
  input  logic          verify_en,
  input  logic          start,
  output logic          spi_wr_req,
  output logic          spi_rd_req,
  output logic [6:0]    spi_addr,
  output logic [7:0]    spi_wdata,
  input  logic          spi_done,
  input  logic [7:0]    spi_rdata,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [7:0]    err_cnt,
  output logic [6:0]    fail_addr,
  output logic [AW:0]   ptr
);

  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [RW-1:0] RETRY_INIT = RW'(MAX_RETRY);
  localparam logic [GW-1:0] GAP_INIT   = GW'(GAP - 1);
  localparam logic [AW:0]   DEPTH_W    = (AW+1)'(DEPTH);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_WRITE, S_GAP_W, S_READ, S_GAP_R, S_CHECK, S_NEXT, S_FINISH
  } state_t;

  state_t state, state_nxt;

  logic [6:0]    tbl_addr_mem [DEPTH];
  logic [7:0]    tbl_data_mem [DEPTH];
  logic [AW:0]   cnt;
  logic [AW:0]   n_clamp;
  logic [AW:0]   ptr_inc;
  logic          verify_q;
  logic [RW-1:0] retry_left;
  logic [GW-1:0] gap_cnt;
  logic [7:0]    rdata_q;
  logic          rd_match;

  assign n_clamp  = (n_pairs > DEPTH_W) ? DEPTH_W : n_pairs;
  assign ptr_inc  = ptr + (AW+1)'(1);
  assign rd_match = (rdata_q == spi_wdata);

  // Host table writes; locked out while a run is walking the table. Not reset.
  always_ff @(posedge FSM_Clk) begin
    if (tbl_we && !busy) begin
      tbl_addr_mem[tbl_idx] <= tbl_addr;
      tbl_data_mem[tbl_idx] <= tbl_data;
    end
  end

  // State register.
  always_ff @(posedge FSM_Clk) begin
    if (Reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode; request levels come straight from the state.
  always_comb begin
    state_nxt  = state;
    spi_wr_req = 1'b0;
    spi_rd_req = 1'b0;
    case (state)
      S_IDLE:   if (start) state_nxt = (n_clamp == '0) ? S_FINISH : S_FETCH;
      S_FETCH:  state_nxt = S_WRITE;
      S_WRITE: begin
        spi_wr_req = 1'b1;
        if (spi_done) state_nxt = S_GAP_W;
      end
      S_GAP_W:  if (gap_cnt == '0) state_nxt = verify_q ? S_READ : S_NEXT;
      S_READ: begin
        spi_rd_req = 1'b1;
        if (spi_done) state_nxt = S_GAP_R;
      end
      S_GAP_R:  if (gap_cnt == '0) state_nxt = S_CHECK;
      S_CHECK: begin
        if (!rd_match && retry_left != '0) state_nxt = S_WRITE;
        else                               state_nxt = S_NEXT;
      end
      S_NEXT:   state_nxt = (ptr_inc < cnt) ? S_FETCH : S_FINISH;
      S_FINISH: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Datapath: run setup, entry fetch, gap timer, read-back capture and error bookkeeping.
  always_ff @(posedge FSM_Clk) begin
    if (Reset) begin
      cnt        <= '0;
      verify_q   <= 1'b0;
      ptr        <= '0;
      spi_addr   <= '0;
      spi_wdata  <= '0;
      retry_left <= '0;
      gap_cnt    <= '0;
      rdata_q    <= '0;
      err        <= 1'b0;
      err_cnt    <= '0;
      fail_addr  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            cnt      <= n_clamp;
            verify_q <= verify_en;
            ptr      <= '0;
            err      <= 1'b0;
            err_cnt  <= '0;
            busy     <= 1'b1;
          end
        end
        S_FETCH: begin
          spi_addr   <= tbl_addr_mem[ptr[AW-1:0]];
          spi_wdata  <= tbl_data_mem[ptr[AW-1:0]];
          retry_left <= RETRY_INIT;
        end
        S_WRITE: if (spi_done) gap_cnt <= GAP_INIT;
        S_READ: begin
          if (spi_done) begin
            rdata_q <= spi_rdata;
            gap_cnt <= GAP_INIT;
          end
        end
        S_GAP_W, S_GAP_R: if (gap_cnt != '0) gap_cnt <= gap_cnt - GW'(1);
        S_CHECK: begin
          if (!rd_match) begin
            if (retry_left != '0) begin
              retry_left <= retry_left - RW'(1);
            end else begin
              err       <= 1'b1;
              fail_addr <= spi_addr;
              if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
            end
          end
        end
        S_NEXT:   ptr <= ptr_inc;
        S_FINISH: begin
          done <= 1'b1;
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_cfg_sequencer.sv
`timescale 1ns/1ps
// tb_spi_cfg_sequencer
// Directed and randomized runs against a sensor/engine responder and a
// transaction-list reference model built from the entry/retry rules.
module tb_spi_cfg_sequencer;

  localparam int DEPTH     = 16;
  localparam int MAX_RETRY = 2;
  localparam int GAP       = 2;

  logic       FSM_Clk = 1'b0;
  logic       Reset;
  logic       tbl_we;
  logic [3:0] tbl_idx;
  logic [6:0] tbl_addr;
  logic [7:0] tbl_data;
  logic [4:0] n_pairs;
  logic       verify_en;
  logic       start;
  logic       spi_wr_req;
  logic       spi_rd_req;
  logic [6:0] spi_addr;
  logic [7:0] spi_wdata;
  logic       spi_done;
  logic [7:0] spi_rdata;
  logic       busy;
  logic       done;
  logic       err;
  logic [7:0] err_cnt;
  logic [6:0] fail_addr;
  logic [4:0] ptr;

  spi_cfg_sequencer #(.DEPTH(DEPTH), .MAX_RETRY(MAX_RETRY), .GAP(GAP)) dut (
    .FSM_Clk   (FSM_Clk),
    .Reset     (Reset),
    .tbl_we    (tbl_we),
    .tbl_idx   (tbl_idx),
    .tbl_addr  (tbl_addr),
    .tbl_data  (tbl_data),
    .n_pairs   (n_pairs),
    .verify_en (verify_en),
    .start     (start),
    .spi_wr_req(spi_wr_req),
    .spi_rd_req(spi_rd_req),
    .spi_addr  (spi_addr),
    .spi_wdata (spi_wdata),
    .spi_done  (spi_done),
    .spi_rdata (spi_rdata),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .err_cnt   (err_cnt),
    .fail_addr (fail_addr),
    .ptr       (ptr)
  );

  always #5 FSM_Clk = ~FSM_Clk;

  int errors = 0;
  int checks = 0;

  // reference state: table image, sensor behaviour, sticky fail address
  logic [6:0]  m_addr [DEPTH];
  logic [7:0]  m_data [DEPTH];
  logic [6:0]  m_fail_addr;
  int          fail_n [128];
  int          rd_cnt [128];
  logic [7:0]  sensor [128];

  // responder / protocol monitor state
  logic [15:0] log_q [$];
  logic [15:0] exp_q [$];
  bit          hold, stray;
  bit          both_seen, unstable, prev_act, seen_txn;
  int          low_run, min_gap, lat;
  logic [6:0]  rsp_a, txn_addr;
  logic [7:0]  txn_wd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // SPI engine + sensor model: random completion latency, echo or corrupt read-backs
  initial begin
    spi_done = 1'b0; spi_rdata = 8'h00; lat = 1;
    prev_act = 0; seen_txn = 0; low_run = 0; min_gap = 1000;
    both_seen = 0; unstable = 0;
    forever begin
      @(negedge FSM_Clk);
      spi_done = 1'b0;
      if (spi_wr_req && spi_rd_req) both_seen = 1;
      if (spi_wr_req || spi_rd_req) begin
        if (!prev_act) begin
          if (seen_txn && low_run < min_gap) min_gap = low_run;
          txn_addr = spi_addr;
          txn_wd   = spi_wdata;
        end else if (spi_addr !== txn_addr || spi_wdata !== txn_wd) begin
          unstable = 1;
        end
        prev_act = 1; seen_txn = 1; low_run = 0;
      end else begin
        prev_act = 0;
        low_run++;
      end
      if (stray) begin
        spi_done = 1'b1;
      end else if ((spi_wr_req || spi_rd_req) && !hold) begin
        if (lat == 0) begin
          spi_done = 1'b1;
          rsp_a = spi_addr;
          if (spi_wr_req) begin
            sensor[rsp_a] = spi_wdata;
            spi_rdata = 8'($urandom);
            log_q.push_back({1'b0, rsp_a, spi_wdata});
          end else begin
            if (rd_cnt[rsp_a] < fail_n[rsp_a])
              spi_rdata = (sensor[rsp_a] == 8'h00) ? 8'hFF : 8'h00;
            else
              spi_rdata = sensor[rsp_a];
            rd_cnt[rsp_a]++;
            log_q.push_back({1'b1, rsp_a, spi_wdata});
          end
          lat = $urandom_range(0, 3);
        end else begin
          lat--;
        end
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic load(input int idx, input logic [6:0] a, input logic [7:0] d);
    @(negedge FSM_Clk);
    tbl_we = 1'b1; tbl_idx = 4'(idx); tbl_addr = a; tbl_data = d;
    @(negedge FSM_Clk);
    tbl_we = 1'b0;
    m_addr[idx] = a;
    m_data[idx] = d;
  endtask

  task automatic run(input int n, input bit ver, input bit glitch);
    int cnt, k, first_wr, e_cnt;
    bit e_err, got_done;
    logic [6:0] a;
    logic [7:0] d;
    cnt = (n > DEPTH) ? DEPTH : n;
    exp_q.delete();
    e_cnt = 0; e_err = 0;
    for (int i = 0; i < cnt; i++) begin
      a = m_addr[i];
      d = m_data[i];
      for (int t = 0; t <= MAX_RETRY; t++) begin
        exp_q.push_back({1'b0, a, d});
        if (!ver) break;
        exp_q.push_back({1'b1, a, d});
        if (t >= fail_n[a]) break;
        if (t == MAX_RETRY) begin
          e_err = 1;
          if (e_cnt < 255) e_cnt++;
          m_fail_addr = a;
        end
      end
    end
    for (int i = 0; i < 128; i++) rd_cnt[i] = 0;
    log_q.delete();
    @(negedge FSM_Clk);
    seen_txn = 0; min_gap = 1000; both_seen = 0; unstable = 0;
    n_pairs = 5'(n); verify_en = ver; start = 1'b1;
    k = 0; got_done = 0; first_wr = -1;
    while (!got_done && k < 4000) begin
      @(negedge FSM_Clk);
      k++;
      if (k == 1) begin
        start = 1'b0;
        check("busy_after_start", busy, 1);
      end
      if (glitch) begin
        case (k)
          5: begin start = 1'b1; n_pairs = 5'd3; verify_en = ~ver; end
          6: start = 1'b0;
          7: begin tbl_we = 1'b1; tbl_idx = 4'd0; tbl_addr = 7'h7F; tbl_data = 8'hEE; end
          8: tbl_we = 1'b0;
          default: ;
        endcase
      end
      if (spi_wr_req && first_wr < 0) first_wr = k;
      if (done) got_done = 1;
    end
    start = 1'b0; tbl_we = 1'b0;
    check("done_seen", got_done, 1);
    check("busy_low_at_done", busy, 0);
    if (cnt == 0) begin
      check("empty_done_latency", k, 2);
      check("empty_no_req", (first_wr < 0), 1);
    end else begin
      check("first_wr_latency", first_wr, 2);
    end
    check("txn_count", log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < log_q.size()) check($sformatf("txn%0d", i), log_q[i], exp_q[i]);
    check("err", err, e_err);
    check("err_cnt", err_cnt, e_cnt);
    check("fail_addr", fail_addr, m_fail_addr);
    check("ptr_end", ptr, cnt);
    check("one_req_only", both_seen, 0);
    check("req_fields_stable", unstable, 0);
    if (exp_q.size() > 1) check("gap_min", (min_gap >= GAP), 1);
    @(negedge FSM_Clk);
    check("done_one_cycle", done, 0);
  endtask

  task automatic stray_test();
    logic [4:0] p0;
    bit bad;
    p0 = ptr; bad = 0;
    @(negedge FSM_Clk);
    stray = 1;
    repeat (4) begin
      @(negedge FSM_Clk);
      if (spi_wr_req || spi_rd_req || busy || done) bad = 1;
    end
    stray = 0;
    repeat (2) begin
      @(negedge FSM_Clk);
      if (spi_wr_req || spi_rd_req || busy || done) bad = 1;
    end
    check("idle_done_ignored", bad, 0);
    check("idle_ptr_held", ptr, p0);
  endtask

  task automatic reset_test();
    int k;
    hold = 1;
    @(negedge FSM_Clk);
    n_pairs = 5'd4; verify_en = 1'b0; start = 1'b1;
    @(negedge FSM_Clk);
    start = 1'b0;
    k = 0;
    while (!spi_wr_req && k < 20) begin
      @(negedge FSM_Clk);
      k++;
    end
    check("rst_wr_req_seen", spi_wr_req, 1);
    Reset = 1'b1;
    @(negedge FSM_Clk);
    check("rst_wr_req", spi_wr_req, 0);
    check("rst_rd_req", spi_rd_req, 0);
    check("rst_spi_addr", spi_addr, 0);
    check("rst_spi_wdata", spi_wdata, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_fail_addr", fail_addr, 0);
    check("rst_ptr", ptr, 0);
    Reset = 1'b0;
    hold = 0;
    m_fail_addr = '0;
    for (int i = 0; i < 128; i++) fail_n[i] = 0;
    run(4, 1, 0);
  endtask

  initial begin
    Reset = 1'b1; tbl_we = 1'b0; tbl_idx = '0; tbl_addr = '0; tbl_data = '0;
    n_pairs = '0; verify_en = 1'b0; start = 1'b0; hold = 0; stray = 0;
    m_fail_addr = '0;
    for (int i = 0; i < 128; i++) begin
      fail_n[i] = 0; rd_cnt[i] = 0; sensor[i] = 8'h00;
    end
    repeat (3) @(negedge FSM_Clk);
    check("reset_wr_req", spi_wr_req, 0);
    check("reset_rd_req", spi_rd_req, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_err", err, 0);
    check("reset_err_cnt", err_cnt, 0);
    check("reset_fail_addr", fail_addr, 0);
    check("reset_ptr", ptr, 0);
    check("reset_spi_addr", spi_addr, 0);
    Reset = 1'b0;

    load(0, 7'h39, 8'h01);
    load(1, 7'h3A, 8'h80);
    run(2, 0, 0);
    run(2, 1, 0);
    fail_n[7'h3A] = 99;
    run(2, 1, 0);
    fail_n[7'h3A] = 0;
    run(0, 0, 0);

    for (int i = 0; i < DEPTH; i++) load(i, {3'($urandom), 4'(i)}, 8'($urandom));
    run(31, 0, 0);
    stray_test();

    repeat (6) begin
      for (int i = 0; i < 128; i++)
        fail_n[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
      run(int'($urandom_range(0, 31)), bit'($urandom_range(0, 1)), 0);
    end

    for (int i = 0; i < 128; i++) fail_n[i] = 0;
    fail_n[m_addr[2]] = 5;
    run(8, 1, 1);
    stray_test();

    reset_test();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
